control_pipe: RTL
=================

Name: control_pipe

Overview:
Pipelined successor to the single-cycle main control decoder. Decodes the ID-stage opcode into a control bundle and carries it through the ID/EX, EX/MEM and MEM/WB control registers. Detects load-use hazards and generates PC/IF-ID stall signals. Handles jump and branch-taken flushes by bubble insertion, and traps illegal opcodes instead of driving X.

Parameters:
OPCODE_W, 6, opcode field width
REG_W, 5, register specifier width
ALUOP_W, 3, ALU operation code width (widened from 2 to encode immediate ops)
HAZARD_EN, 1, 1 = load-use stall logic active; 0 = stall outputs tied inactive

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
id_opcode  in  OPCODE_W  opcode of the instruction in ID
id_valid  in  1  IF/ID holds a real instruction (0 = bubble)
id_rs  in  REG_W  rs of ID instruction
id_rt  in  REG_W  rt of ID instruction
mem_branch_taken  in  1  branch in MEM resolved taken
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID register enable
if_flush  out  1  clear IF/ID (jump in ID or branch taken)
ex_reg_dst, ex_alu_src, ex_zero_ext  out  1 each  EX controls
ex_alu_op  out  ALUOP_W  EX ALU op class
ex_rt  out  REG_W  rt carried with the EX instruction
mem_read, mem_write, mem_branch, mem_bne  out  1 each  MEM controls
wb_reg_write, wb_mem_to_reg  out  1 each  WB controls
illegal_op  out  1  sticky illegal-opcode flag
illegal_opcode  out  OPCODE_W  first offending opcode captured

Behaviour:
- Decode (combinational, ID) for R=0, LW=35, SW=43, BEQ=4, BNE=5, J=2, ORI=13, ADDI=8, ANDI=12, SLTI=10.
- ALUOp encoding: 000 add (LW/SW/ADDI), 001 sub (BEQ/BNE), 010 funct (R), 011 or (ORI), 100 and (ANDI), 101 slt (SLTI).
- zero_ext=1 for ORI and ANDI only.
- Immediate ALU ops: reg_dst=0, alu_src=1, reg_write=1, mem_to_reg=0.
- Don't-care fields are driven 0, never X. Every stage register bit is known at all times.
- J: if_flush=1 in the same cycle. It enters ID/EX as a bubble (no register write, no branch). The jump target mux is external.
- Bubble = all control bits 0, ex_rt=0.
- Stage registers: ID/EX is loaded from decode each cycle. EX/MEM takes the MEM+WB subset of ID/EX. MEM/WB takes the WB subset of EX/MEM. Latency: opcode to ex_* = 1 cycle, to mem_* = 2 cycles, to wb_* = 3 cycles.
- Load-use hazard (HAZARD_EN=1):
  - Condition: id_valid & ID/EX.mem_read & ex_rt!=0 & (ex_rt==id_rs | (ex_rt==id_rt & uses_rt)), where uses_rt = R, SW, BEQ, BNE.
  - Response: pc_write=0, ifid_write=0, ID/EX loaded with a bubble. Exactly one stall cycle per load.
- Branch taken (mem_branch_taken=1):
  - if_flush=1; ID/EX and EX/MEM loaded with bubbles next edge; MEM/WB loads normally.
  - Overrides stall: pc_write=1, ifid_write=1.
- Priority: rst > mem_branch_taken > load-use stall > J flush > normal.
- id_valid=0: decode is forced to a bubble, no hazard, no illegal trap.
- Illegal opcode (id_valid=1, not in the decode list):
  - Bubble is inserted.
  - If illegal_op was 0: illegal_op<=1 and illegal_opcode<=id_opcode. Later illegal opcodes do not overwrite the capture.
  - Cleared only by rst.
  - An illegal opcode squashed by the same-cycle branch flush does not trap.
- Reset (synchronous): all stage registers are bubbles, illegal_op=0, illegal_opcode=0. After reset, pc_write=1, ifid_write=1, if_flush=0. Reset asserted mid-stall cancels the stall on the next edge.
- HAZARD_EN=0: pc_write=ifid_write=1 except under rst. No bubble is inserted for load-use.

Decomposition:
- Shared package mips_ctrl_pkg: opcode constants, ALUOP_* encodings, and packed struct types ex_ctrl_t, mem_ctrl_t, wb_ctrl_t with a BUBBLE constant for each.
- One sub-module, control_decode: purely combinational opcode to {ex,mem,wb,uses_rt,illegal,is_jump}.
- control_pipe holds the stage registers, hazard logic and trap.

Test Plan:
- Reset, then issue ADDI (8): ex_alu_op=000, ex_alu_src=1 at cycle+1; wb_reg_write=1, wb_mem_to_reg=0 at cycle+3.
- LW with rt=5, then R-type with rs=5: one cycle of pc_write=0, ifid_write=0, bubble in EX; R-type appears in EX the following cycle. Repeat with rt=0: no stall.
- BEQ resolved taken in MEM while LW-dependent stall is pending: if_flush=1, pc_write=1; EX and MEM controls are all 0 next cycle; the older WB instruction completes.
- J (2) in ID: if_flush=1 the same cycle; all EX controls 0 next cycle.
- Opcode 63 then opcode 62: illegal_op=1, illegal_opcode=63 (not 62); both decode to bubbles; rst clears both fields to 0.
- ORI (13) with HAZARD_EN=0 after LW to the same register: no stall; ex_zero_ext=1, ex_alu_op=011.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared opcode map, ALU op classes and per-stage control bundles for the
// pipelined main control.
package mips_ctrl_pkg;

  localparam int OP_W  = 6;
  localparam int ALU_W = 3;

  localparam logic [OP_W-1:0] OP_R    = 6'd0;
  localparam logic [OP_W-1:0] OP_J    = 6'd2;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'd4;
  localparam logic [OP_W-1:0] OP_BNE  = 6'd5;
  localparam logic [OP_W-1:0] OP_ADDI = 6'd8;
  localparam logic [OP_W-1:0] OP_SLTI = 6'd10;
  localparam logic [OP_W-1:0] OP_ANDI = 6'd12;
  localparam logic [OP_W-1:0] OP_ORI  = 6'd13;
  localparam logic [OP_W-1:0] OP_LW   = 6'd35;
  localparam logic [OP_W-1:0] OP_SW   = 6'd43;

  localparam logic [ALU_W-1:0] ALUOP_ADD   = 3'b000;
  localparam logic [ALU_W-1:0] ALUOP_SUB   = 3'b001;
  localparam logic [ALU_W-1:0] ALUOP_FUNCT = 3'b010;
  localparam logic [ALU_W-1:0] ALUOP_OR    = 3'b011;
  localparam logic [ALU_W-1:0] ALUOP_AND   = 3'b100;
  localparam logic [ALU_W-1:0] ALUOP_SLT   = 3'b101;

  typedef struct packed {
    logic             reg_dst;
    logic             alu_src;
    logic             zero_ext;
    logic [ALU_W-1:0] alu_op;
  } ex_ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic branch;
    logic bne;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  localparam ex_ctrl_t  EX_BUBBLE  = '0;
  localparam mem_ctrl_t MEM_BUBBLE = '0;
  localparam wb_ctrl_t  WB_BUBBLE  = '0;

endpackage

// File: rtl/control_decode.sv
// Combinational ID-stage decode: opcode to EX/MEM/WB control bundles plus
// hazard/flush/trap qualifiers. Anything not a live, legal instruction is a bubble.
module control_decode
  import mips_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  input  logic            valid,
  output ex_ctrl_t        ex,
  output mem_ctrl_t       mem,
  output wb_ctrl_t        wb,
  output logic            uses_rt,
  output logic            illegal,
  output logic            is_jump
);

  always_comb begin
    ex      = EX_BUBBLE;
    mem     = MEM_BUBBLE;
    wb      = WB_BUBBLE;
    uses_rt = 1'b0;
    illegal = 1'b0;
    is_jump = 1'b0;
    if (valid) begin
      case (opcode)
        OP_R: begin
          ex.reg_dst   = 1'b1;
          ex.alu_op    = ALUOP_FUNCT;
          wb.reg_write = 1'b1;
          uses_rt      = 1'b1;
        end
        OP_LW: begin
          ex.alu_src    = 1'b1;
          mem.mem_read  = 1'b1;
          wb.reg_write  = 1'b1;
          wb.mem_to_reg = 1'b1;
        end
        OP_SW: begin
          ex.alu_src    = 1'b1;
          mem.mem_write = 1'b1;
          uses_rt       = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          ex.alu_op  = ALUOP_SUB;
          mem.branch = 1'b1;
          mem.bne    = (opcode == OP_BNE);
          uses_rt    = 1'b1;
        end
        OP_J: is_jump = 1'b1;
        // Immediate ALU ops share everything but the op class and extension.
        OP_ADDI, OP_ORI, OP_ANDI, OP_SLTI: begin
          ex.alu_src   = 1'b1;
          ex.zero_ext  = (opcode == OP_ORI) || (opcode == OP_ANDI);
          wb.reg_write = 1'b1;
          case (opcode)
            OP_ORI:  ex.alu_op = ALUOP_OR;
            OP_ANDI: ex.alu_op = ALUOP_AND;
            OP_SLTI: ex.alu_op = ALUOP_SLT;
            default: ex.alu_op = ALUOP_ADD;
          endcase
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/control_pipe.sv
// Pipelined main control: ID decode, ID/EX, EX/MEM and MEM/WB control
// registers, load-use stall, jump/branch flush and sticky illegal-opcode trap.
module control_pipe
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W  = 6,
  parameter int REG_W     = 5,
  parameter int ALUOP_W   = 3,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] id_opcode,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic                mem_branch_taken,
  output logic                pc_write,
  output logic                ifid_write,
  output logic                if_flush,
  output logic                ex_reg_dst,
  output logic                ex_alu_src,
  output logic                ex_zero_ext,
  output logic [ALUOP_W-1:0]  ex_alu_op,
  output logic [REG_W-1:0]    ex_rt,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_branch,
  output logic                mem_bne,
  output logic                wb_reg_write,
  output logic                wb_mem_to_reg,
  output logic                illegal_op,
  output logic [OPCODE_W-1:0] illegal_opcode
);

  ex_ctrl_t   dec_ex, idex_ex;
  mem_ctrl_t  dec_mem, idex_mem, exmem_mem;
  wb_ctrl_t   dec_wb, idex_wb, exmem_wb, memwb_wb;
  logic [REG_W-1:0] idex_rt;
  logic dec_uses_rt, dec_illegal, dec_jump, dec_live;
  logic hazard, stall;

  control_decode u_dec (
    .opcode  (id_opcode),
    .valid   (id_valid),
    .ex      (dec_ex),
    .mem     (dec_mem),
    .wb      (dec_wb),
    .uses_rt (dec_uses_rt),
    .illegal (dec_illegal),
    .is_jump (dec_jump)
  );

  // rt travels only with real instructions so bubbles stay all-zero.
  assign dec_live = id_valid & ~dec_illegal & ~dec_jump;

  assign hazard = id_valid & idex_mem.mem_read & (idex_rt != '0) &
                  ((idex_rt == id_rs) | ((idex_rt == id_rt) & dec_uses_rt));
  // A taken branch squashes the dependent instruction, so it wins over the stall.
  assign stall  = HAZARD_EN & hazard & ~mem_branch_taken & ~rst;

  assign pc_write   = ~rst & ~stall;
  assign ifid_write = ~rst & ~stall;
  assign if_flush   = ~rst & (mem_branch_taken | (dec_jump & ~stall));

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_ex        <= EX_BUBBLE;
      idex_mem       <= MEM_BUBBLE;
      idex_wb        <= WB_BUBBLE;
      idex_rt        <= '0;
      exmem_mem      <= MEM_BUBBLE;
      exmem_wb       <= WB_BUBBLE;
      memwb_wb       <= WB_BUBBLE;
      illegal_op     <= 1'b0;
      illegal_opcode <= '0;
    end else begin
      if (mem_branch_taken || stall) begin
        idex_ex  <= EX_BUBBLE;
        idex_mem <= MEM_BUBBLE;
        idex_wb  <= WB_BUBBLE;
        idex_rt  <= '0;
      end else begin
        idex_ex  <= dec_ex;
        idex_mem <= dec_mem;
        idex_wb  <= dec_wb;
        idex_rt  <= dec_live ? id_rt : '0;
      end
      if (mem_branch_taken) begin
        exmem_mem <= MEM_BUBBLE;
        exmem_wb  <= WB_BUBBLE;
      end else begin
        exmem_mem <= idex_mem;
        exmem_wb  <= idex_wb;
      end
      memwb_wb <= exmem_wb;
      if (dec_illegal && !mem_branch_taken && !illegal_op) begin
        illegal_op     <= 1'b1;
        illegal_opcode <= id_opcode;
      end
    end
  end

  assign ex_reg_dst    = idex_ex.reg_dst;
  assign ex_alu_src    = idex_ex.alu_src;
  assign ex_zero_ext   = idex_ex.zero_ext;
  assign ex_alu_op     = idex_ex.alu_op;
  assign ex_rt         = idex_rt;
  assign mem_read      = exmem_mem.mem_read;
  assign mem_write     = exmem_mem.mem_write;
  assign mem_branch    = exmem_mem.branch;
  assign mem_bne       = exmem_mem.bne;
  assign wb_reg_write  = memwb_wb.reg_write;
  assign wb_mem_to_reg = memwb_wb.mem_to_reg;

endmodule
